// File: rtl/dp4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dp4_rr_scheduler
// Description : Round-robin front end that shares a single DP4 FP32 4-D
//               dot-product unit among NREQ requesters. Each grant captures
//               one operand set, holds it on the DP4 inputs for LAT cycles,
//               samples the result and returns it tagged with the requester.
// Revision    : 1.0 - initial release
// ============================================================================
module dp4_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     i_req_valid,
  output logic [NREQ-1:0]     o_req_ready,
  input  logic [NREQ*128-1:0] i_req_a,
  input  logic [NREQ*128-1:0] i_req_b,
  output logic [127:0]        o_dp_a,
  output logic [127:0]        o_dp_b,
  input  logic [31:0]         i_dp_out,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [31:0]         o_rsp_data,
  output logic [ID_W-1:0]     o_rsp_id,
  output logic                o_busy
);

  // LAT==1 still needs a 1-bit counter that is simply loaded with zero
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_grant;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_rot;
  logic [NREQ-1:0]  w_grant_oh;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_grant_any;
  int               w_off;
  int               w_idx;

  // Round-robin pick: rotate the request vector so bit 0 is the requester
  // just after the last grant, take the lowest set bit, then un-rotate.
  always_comb begin
    w_rot       = NREQ'({i_req_valid, i_req_valid} >> (int'(r_last) + 1));
    w_off       = 0;
    w_grant_any = 1'b0;
    for (int m = NREQ - 1; m >= 0; m--) begin
      if (w_rot[m]) begin
        w_off       = m;
        w_grant_any = 1'b1;
      end
    end
    w_idx = int'(r_last) + 1 + w_off;
    if (w_idx >= NREQ) begin
      w_idx = w_idx - NREQ;
    end
    w_grant_idx = ID_W'(w_idx);
    w_grant_oh  = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_grant_oh[j] = w_grant_any && (w_idx == j);
    end
  end

  // Grants are only offered while idle; reset forces them low immediately
  assign o_req_ready = (r_state == S_IDLE && !rst) ? w_grant_oh : '0;

  // Scheduler FSM: accept -> hold operands LAT cycles -> present response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(NREQ - 1);
      r_grant     <= '0;
      r_cnt       <= '0;
      o_dp_a      <= '0;
      o_dp_b      <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            o_dp_a  <= i_req_a[w_idx*128 +: 128];
            o_dp_b  <= i_req_b[w_idx*128 +: 128];
            r_grant <= w_grant_idx;
            r_cnt   <= CNT_W'(LAT - 1);
            o_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            o_rsp_data  <= i_dp_out;
            o_rsp_id    <= r_grant;
            o_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // The pointer only advances once the result has been taken
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            r_last      <= r_grant;
            o_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp4_rr_scheduler
// Description : Directed self-checking bench for dp4_rr_scheduler (LAT=2 and
//               LAT=1 instances) with a behavioural DP4 stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp4_rr_scheduler;

  localparam int LAT0 = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [3:0]   valid0 = '0, ready0;
  logic [511:0] req_a0, req_b0;
  logic [127:0] dp_a0, dp_b0;
  logic [31:0]  dp_out0, rsp_data0;
  logic         rsp_valid0, rsp_ready0 = 1'b0, busy0;
  logic [1:0]   rsp_id0;

  logic [3:0]   valid1 = '0, ready1;
  logic [511:0] req_a1, req_b1;
  logic [127:0] dp_a1, dp_b1;
  logic [31:0]  dp_out1, rsp_data1;
  logic         rsp_valid1, rsp_ready1 = 1'b0, busy1;
  logic [1:0]   rsp_id1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural DP4: exact FP results for the known vectors, a hash otherwise
  function automatic logic [31:0] dp4(input logic [127:0] a, input logic [127:0] b);
    if (a == {4{32'h3F800000}} && b == {4{32'h40000000}}) return 32'h41000000;
    if (a == {64'h0, 32'h40000000, 32'h3F800000} && b == {64'h0, 32'h3F000000, 32'h40400000})
      return 32'h40800000;
    return a[31:0] ^ a[63:32] ^ a[95:64] ^ a[127:96] ^ {b[15:0], b[31:16]} ^ b[63:32] ^ b[95:64] ^ b[127:96];
  endfunction

  function automatic logic [127:0] op_a(input int i);
    logic [127:0] r;
    if (i == 0) return {4{32'h3F800000}};
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {8'hA0, 8'(i), 8'(k), 8'h5A};
    return r;
  endfunction

  function automatic logic [127:0] op_b(input int i);
    logic [127:0] r;
    if (i == 0) return {4{32'h40000000}};
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {8'hB0, 8'(i), 8'(k), 8'hC3};
    return r;
  endfunction

  assign dp_out0 = dp4(dp_a0, dp_b0);
  assign dp_out1 = dp4(dp_a1, dp_b1);

  dp4_rr_scheduler #(.NREQ(4), .LAT(LAT0), .ID_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(valid0), .o_req_ready(ready0),
    .i_req_a(req_a0), .i_req_b(req_b0),
    .o_dp_a(dp_a0), .o_dp_b(dp_b0), .i_dp_out(dp_out0),
    .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
    .o_rsp_data(rsp_data0), .o_rsp_id(rsp_id0), .o_busy(busy0)
  );

  dp4_rr_scheduler #(.NREQ(4), .LAT(1), .ID_W(2)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .i_req_valid(valid1), .o_req_ready(ready1),
    .i_req_a(req_a1), .i_req_b(req_b1),
    .o_dp_a(dp_a1), .o_dp_b(dp_b1), .i_dp_out(dp_out1),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1),
    .o_rsp_data(rsp_data1), .o_rsp_id(rsp_id1), .o_busy(busy1)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete operation on the LAT=2 instance, optional response backpressure
  task automatic do_op(input logic [3:0] mask, input int exp_id, input int bp);
    int cyc;
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    @(negedge clk);
    valid0 = mask;
    rsp_ready0 = 1'b0;
    #1;
    chk("grant_onehot", ready0, oh);
    @(negedge clk); #1;
    chk("ready_after_accept", ready0, 4'b0000);
    chk("busy_wait", busy0, 1'b1);
    chk("dp_a", dp_a0, op_a(exp_id));
    chk("dp_b", dp_b0, op_b(exp_id));
    valid0 = '0;
    cyc = 1;
    while (rsp_valid0 !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("accept_to_rsp", cyc, LAT0 + 1);
    chk("rsp_id", rsp_id0, exp_id);
    chk("rsp_data", rsp_data0, dp4(op_a(exp_id), op_b(exp_id)));
    if (bp > 0) begin
      valid0 = 4'hF;
      for (int c = 0; c < bp; c++) begin
        @(negedge clk); #1;
        chk("bp_valid", rsp_valid0, 1'b1);
        chk("bp_id", rsp_id0, exp_id);
        chk("bp_data", rsp_data0, dp4(op_a(exp_id), op_b(exp_id)));
        chk("bp_busy", busy0, 1'b1);
        chk("bp_ready", ready0, 4'b0000);
      end
    end
    valid0 = '0;
    rsp_ready0 = 1'b1;
    @(negedge clk); #1;
    chk("rsp_done", rsp_valid0, 1'b0);
    chk("idle_busy", busy0, 1'b0);
    rsp_ready0 = 1'b0;
  endtask

  typedef struct {
    logic [3:0] mask;
    int         exp_id;
    int         bp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int cyc, n_rsp, last_acc, exp_acc, exp_rsp, n_bad;
    logic [3:0] oh;

    // Operation sequence from reset; grant follows the rotating pointer
    tbl[0]  = '{4'b0001, 0, 0};
    tbl[1]  = '{4'b1111, 1, 0};
    tbl[2]  = '{4'b1111, 2, 10};
    tbl[3]  = '{4'b1111, 3, 0};
    tbl[4]  = '{4'b1111, 0, 0};
    tbl[5]  = '{4'b0100, 2, 0};
    tbl[6]  = '{4'b1010, 3, 0};
    tbl[7]  = '{4'b1010, 1, 0};
    tbl[8]  = '{4'b1001, 3, 0};
    tbl[9]  = '{4'b1001, 0, 0};
    tbl[10] = '{4'b0011, 1, 0};
    tbl[11] = '{4'b0001, 0, 0};

    for (int i = 0; i < 4; i++) begin
      req_a0[128*i +: 128] = op_a(i);
      req_b0[128*i +: 128] = op_b(i);
    end
    req_a1 = '0;
    req_b1 = '0;
    req_a1[127:0] = {64'h0, 32'h40000000, 32'h3F800000};
    req_b1[127:0] = {64'h0, 32'h3F000000, 32'h40400000};

    // Reset state
    valid0 = 4'hF;
    #12;
    chk("rst_ready", ready0, 4'b0000);
    chk("rst_dp_a", dp_a0, 128'h0);
    chk("rst_rsp_valid", rsp_valid0, 1'b0);
    chk("rst_rsp_data", rsp_data0, 32'h0);
    chk("rst_busy", busy0, 1'b0);
    valid0 = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 12; t++) begin
      do_op(tbl[t].mask, tbl[t].exp_id, tbl[t].bp);
    end

    // Reset while waiting on an operation granted to req1
    @(negedge clk);
    valid0 = 4'b0011;
    #1;
    chk("pre_rst_grant", ready0, 4'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_ready", ready0, 4'b0000);
    chk("async_dp_a", dp_a0, 128'h0);
    chk("async_dp_b", dp_b0, 128'h0);
    chk("async_rsp_valid", rsp_valid0, 1'b0);
    chk("async_rsp_data", rsp_data0, 32'h0);
    chk("async_rsp_id", rsp_id0, 2'd0);
    chk("async_busy", busy0, 1'b0);
    @(negedge clk);
    valid0 = '0;
    rsp_ready0 = 1'b1;
    rst = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) n_bad++;
    end
    chk("no_rsp_after_rst", n_bad, 0);
    do_op(4'b0011, 0, 0);

    // Continuous requests: strict rotation at one accept per LAT+2 cycles
    @(negedge clk);
    valid0 = 4'hF;
    rsp_ready0 = 1'b1;
    n_rsp = 0;
    last_acc = -1;
    exp_acc = 1;
    exp_rsp = 1;
    cyc = 0;
    while (n_rsp < 8 && cyc < 100) begin
      #1;
      if (ready0 != 4'b0000) begin
        oh = 4'b0001 << exp_acc;
        if (last_acc >= 0) chk("accept_gap", cyc - last_acc, LAT0 + 2);
        chk("rr_grant", ready0, oh);
        exp_acc = (exp_acc + 1) % 4;
        last_acc = cyc;
      end
      if (rsp_valid0) begin
        chk("rr_rsp_id", rsp_id0, exp_rsp);
        chk("rr_rsp_data", rsp_data0, dp4(op_a(exp_rsp), op_b(exp_rsp)));
        exp_rsp = (exp_rsp + 1) % 4;
        n_rsp++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_count", n_rsp, 8);
    valid0 = '0;
    rsp_ready0 = 1'b0;

    // LAT=1 instance: (1,2,0,0).(3,0.5,0,0) = 4.0
    @(negedge clk);
    valid1 = 4'b0001;
    rsp_ready1 = 1'b1;
    #1;
    chk("lat1_grant", ready1, 4'b0001);
    @(negedge clk); #1;
    valid1 = '0;
    cyc = 1;
    while (rsp_valid1 !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("lat1_accept_to_rsp", cyc, 2);
    chk("lat1_rsp_data", rsp_data1, 32'h40800000);
    chk("lat1_rsp_id", rsp_id1, 2'd0);
    @(negedge clk); #1;
    chk("lat1_rsp_done", rsp_valid1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
